// File: rtl/wb_slave_regfile_pkg.sv
// ============================================================================
// Module      : wb_slave_pkg
// Description : Shared types and default widths for the Wishbone register
//               file responder and its wait-state counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_slave_pkg;

    localparam int WB_ADDR_W = 2;
    localparam int WB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_slv_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_slave_regfile_if.sv
// ============================================================================
// Module      : wb_slave_regfile_if
// Description : Wishbone classic bus bundle. Signal names are written from the
//               slave's point of view. Optional err_o under WB_SLAVE_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_slave_regfile_if
    import wb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_W,
    parameter int DATA_WIDTH = WB_DATA_W
);

    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
`ifdef WB_SLAVE_ERR_EN
    logic                  err_o;

    modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i,
                    output dat_o, ack_o, err_o);
    modport master (output cyc_i, stb_i, we_i, adr_i, dat_i,
                    input  dat_o, ack_o, err_o);
`else
    modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i,
                    output dat_o, ack_o);
    modport master (output cyc_i, stb_i, we_i, adr_i, dat_i,
                    input  dat_o, ack_o);
`endif

endinterface

`default_nettype wire

// File: rtl/wb_slave_regfile_wait_counter.sv
// ============================================================================
// Module      : wb_wait_counter
// Description : Loadable wait-state down-counter. Saturates the load value at
//               MAX_WAIT, stops at zero, flags the last wait cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_wait_counter #(
    parameter int MAX_WAIT = 7,
    parameter int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] load_val_i,
    input  wire logic             clr_i,
    output logic                  load_zero_o,
    output logic                  last_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] sat_val;

    always_comb begin
        sat_val = (load_val_i > MAX_C) ? MAX_C : load_val_i;
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = sat_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign load_zero_o = (sat_val == '0);
    assign last_o      = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_slave_regfile.sv
// ============================================================================
// Module      : wb_slave_regfile
// Description : Wishbone classic responder with NUM_REGS registers and a
//               run-time wait-state count. WB_SLAVE_ERR_EN routes
//               out-of-range accesses to err_o instead of ack_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_slave_regfile
    import wb_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = WB_ADDR_W,
    parameter int                    DATA_WIDTH = WB_DATA_W,
    parameter int                    NUM_REGS   = 4,
    parameter int                    MAX_WAIT   = 7,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    localparam int                   WCFG_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  wire logic                           clk_i,
    input  wire logic                           rst_i,
    wb_slave_regfile_if.slave                   bus,
    input  wire logic [WCFG_W-1:0]              wait_cfg_i,
    output logic                                reg_wr_o,
    output logic [ADDR_WIDTH-1:0]               reg_idx_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0]      regs_o
);

    localparam logic [ADDR_WIDTH:0] NUM_REGS_C = (ADDR_WIDTH + 1)'(NUM_REGS);

    wb_slv_state_t state_q, state_d;

    logic                  req;
    logic                  cnt_load;
    logic                  cnt_clr;
    logic                  cnt_load_zero;
    logic                  cnt_last;
    logic                  commit;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_val;

    logic [ADDR_WIDTH-1:0] adr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic                  ack_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] rdat_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
`ifdef WB_SLAVE_ERR_EN
    logic                  err_q;
`endif

    wb_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (WCFG_W)
    ) u_wait_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (cnt_load),
        .load_val_i  (wait_cfg_i),
        .clr_i       (cnt_clr),
        .load_zero_o (cnt_load_zero),
        .last_o      (cnt_last)
    );

    assign req      = bus.cyc_i & bus.stb_i;
    assign in_range = ({1'b0, adr_q} < NUM_REGS_C);

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_load = 1'b1;
                    state_d  = cnt_load_zero ? ACK : WAIT;
                end
            end
            WAIT: begin
                // A dropped cyc/stb wins over the terminal count.
                if (!req) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (cnt_last) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (adr_q == ADDR_WIDTH'(k)) begin
                rd_val = regs_q[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            wr_q    <= 1'b0;
            rdat_q  <= '0;
            idx_q   <= '0;
`ifdef WB_SLAVE_ERR_EN
            err_q   <= 1'b0;
`endif
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            ack_q   <= 1'b0;
            wr_q    <= 1'b0;
            rdat_q  <= '0;
`ifdef WB_SLAVE_ERR_EN
            err_q   <= 1'b0;
`endif
            if (cnt_load) begin
                adr_q  <= bus.adr_i;
                we_q   <= bus.we_i;
                wdat_q <= bus.dat_i;
            end
            if (commit) begin
                idx_q <= adr_q;
                wr_q  <= we_q & in_range;
`ifdef WB_SLAVE_ERR_EN
                ack_q <= in_range;
                err_q <= ~in_range;
`else
                ack_q <= 1'b1;
`endif
                if (!we_q) begin
                    rdat_q <= rd_val;
                end
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (we_q && adr_q == ADDR_WIDTH'(k)) begin
                        regs_q[k] <= wdat_q;
                    end
                end
            end
        end
    end

    assign bus.ack_o = ack_q;
    assign bus.dat_o = rdat_q;
`ifdef WB_SLAVE_ERR_EN
    assign bus.err_o = err_q;
`endif
    assign reg_wr_o  = wr_q;
    assign reg_idx_o = idx_q;

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_wb_slave_regfile.sv
// ============================================================================
// Module      : tb_wb_slave_regfile
// Description : Randomised self-checking bench for wb_slave_regfile built with
//               NUM_REGS=3; honours WB_SLAVE_ERR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_slave_regfile;

    localparam int NREGS = 3;
    localparam int MAXW  = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  wait_cfg = '0;
    logic        reg_wr;
    logic [1:0]  reg_idx;
    logic [23:0] regs;
    logic        err_seen;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_regs [4];
    logic [1:0] model_idx;
    logic [9:0] wr_log [$];

    wb_slave_regfile_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

    wb_slave_regfile #(.NUM_REGS(NREGS), .MAX_WAIT(MAXW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .wait_cfg_i (wait_cfg),
        .reg_wr_o   (reg_wr),
        .reg_idx_o  (reg_idx),
        .regs_o     (regs)
    );

`ifdef WB_SLAVE_ERR_EN
    assign err_seen = bus.err_o;
`else
    assign err_seen = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (reg_wr === 1'b1) wr_log.push_back({reg_idx, regs[reg_idx*8 +: 8]});
        end
    end

    function automatic logic [23:0] model_flat();
        return {model_regs[2], model_regs[1], model_regs[0]};
    endfunction

    function automatic int exp_kind(input logic [1:0] adr);
`ifdef WB_SLAVE_ERR_EN
        return (int'(adr) < NREGS) ? 1 : 2;
`else
        return (adr == adr) ? 1 : 1;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
        model_idx = 2'd0;
    endfunction

    // One classic transfer; kind: 0 none, 1 ack, 2 err. lat counts edges after sampling.
    task automatic xfer(input logic [1:0] adr, input logic we, input logic [7:0] dat,
                        input logic [2:0] wcfg, output int lat, output int kind,
                        output logic [7:0] rdat, output logic wr, output logic [23:0] regs_ack,
                        output logic resp_after, output logic [7:0] dat_after);
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = adr; bus.we_i = we;
        bus.dat_i = dat; wait_cfg = wcfg;
        @(posedge clk); #1;
        wait_cfg = 3'($urandom);
        lat = -1; kind = 0; rdat = 'x; wr = 1'bx; regs_ack = 'x;
        for (int k = 1; k <= MAXW + 4; k++) begin
            @(posedge clk); #1;
            if (bus.ack_o === 1'b1 || err_seen === 1'b1) begin
                lat = k; kind = (bus.ack_o === 1'b1) ? 1 : 2;
                rdat = bus.dat_o; wr = reg_wr; regs_ack = regs;
                break;
            end
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        @(posedge clk); #1;
        resp_after = bus.ack_o | err_seen;
        dat_after  = bus.dat_o;
    endtask

    task automatic test_reset();
        int lat, kind; logic [7:0] rdat, dafter; logic wr, rafter; logic [23:0] ra;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0; bus.dat_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++; if (bus.ack_o !== 1'b0 || reg_wr !== 1'b0 || bus.dat_o !== 8'h00 || reg_idx !== 2'd0) begin
            failures++; $display("FAIL reset_outputs ack=%b wr=%b dat=%h idx=%0d required 0/0/00/0", bus.ack_o, reg_wr, bus.dat_o, reg_idx);
        end
        checks++; if (regs !== 24'h0) begin
            failures++; $display("FAIL reset_regs got=%h required=000000", regs);
        end
        @(negedge clk); rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            xfer(2'(a), 1'b0, 8'h00, 3'd0, lat, kind, rdat, wr, ra, rafter, dafter);
            checks++; if (lat !== 1 || kind !== exp_kind(2'(a))) begin
                failures++; $display("FAIL reset_read_lat adr=%0d lat=%0d kind=%0d required lat=1 kind=%0d", a, lat, kind, exp_kind(2'(a)));
            end
            checks++; if (rdat !== 8'h00 || rafter !== 1'b0 || dafter !== 8'h00) begin
                failures++; $display("FAIL reset_read_data adr=%0d dat=%h after=%b/%h required 00 0/00", a, rdat, rafter, dafter);
            end
            model_idx = 2'(a);
        end
    endtask

    task automatic test_write_wait();
        int lat, kind; logic [7:0] rdat, dafter; logic wr, rafter; logic [23:0] ra;
        xfer(2'd2, 1'b1, 8'hA5, 3'd3, lat, kind, rdat, wr, ra, rafter, dafter);
        model_regs[2] = 8'hA5; model_idx = 2'd2;
        checks++; if (lat !== 4 || kind !== 1 || wr !== 1'b1 || rafter !== 1'b0) begin
            failures++; $display("FAIL write_wait lat=%0d kind=%0d wr=%b after=%b required 4/1/1/0", lat, kind, wr, rafter);
        end
        checks++; if (ra[23:16] !== 8'hA5 || reg_idx !== 2'd2) begin
            failures++; $display("FAIL write_wait_reg reg2=%h idx=%0d required A5/2", ra[23:16], reg_idx);
        end
        xfer(2'd2, 1'b0, 8'h00, 3'd0, lat, kind, rdat, wr, ra, rafter, dafter);
        checks++; if (rdat !== 8'hA5 || wr !== 1'b0 || lat !== 1) begin
            failures++; $display("FAIL read_back dat=%h wr=%b lat=%0d required A5/0/1", rdat, wr, lat);
        end
    endtask

    task automatic test_back_to_back();
        int ack_cyc [$];
        wr_log.delete();
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = 2'd0;
        bus.dat_i = 8'h11; wait_cfg = 3'd0;
        @(posedge clk); #1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (bus.ack_o === 1'b1 || err_seen === 1'b1) begin
                ack_cyc.push_back(k);
                if (ack_cyc.size() == 1) begin
                    bus.adr_i = 2'd1; bus.dat_i = 8'h22;
                end else begin
                    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
                end
            end
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        model_regs[0] = 8'h11; model_regs[1] = 8'h22; model_idx = 2'd1;
        checks++; if (ack_cyc.size() != 2) begin
            failures++; $display("FAIL b2b_ack_count got=%0d required=2", ack_cyc.size());
        end else begin
            checks++; if (ack_cyc[0] != 1 || ack_cyc[1] != 3) begin
                failures++; $display("FAIL b2b_ack_timing got=%0d,%0d required=1,3", ack_cyc[0], ack_cyc[1]);
            end
        end
        checks++; if (wr_log.size() != 2) begin
            failures++; $display("FAIL b2b_monitor_count got=%0d required=2", wr_log.size());
        end else begin
            checks++; if (wr_log[0] !== {2'd0, 8'h11} || wr_log[1] !== {2'd1, 8'h22}) begin
                failures++; $display("FAIL b2b_monitor got=%h,%h required=011,122", wr_log[0], wr_log[1]);
            end
        end
        checks++; if (regs !== model_flat()) begin
            failures++; $display("FAIL b2b_regs got=%h required=%h", regs, model_flat());
        end
    endtask

    task automatic test_abort();
        int lat, kind; logic [7:0] rdat, dafter; logic wr, rafter; logic [23:0] ra;
        logic seen;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = 2'd1;
            bus.dat_i = 8'hFF; wait_cfg = 3'd5;
            @(posedge clk); #1;
            repeat (2) begin @(posedge clk); #1; end
            if (t == 0) bus.cyc_i = 1'b0; else bus.stb_i = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (bus.ack_o !== 1'b0 || err_seen !== 1'b0 || reg_wr !== 1'b0) seen = 1'b1;
            end
            bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
            checks++; if (seen !== 1'b0 || regs !== model_flat() || reg_idx !== model_idx) begin
                failures++; $display("FAIL abort_%0d resp=%b regs=%h idx=%0d required 0/%h/%0d", t, seen, regs, reg_idx, model_flat(), model_idx);
            end
        end
        @(negedge clk);
        bus.stb_i = 1'b1; bus.cyc_i = 1'b0; bus.adr_i = 2'd2; bus.we_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.ack_o !== 1'b0 || err_seen !== 1'b0) seen = 1'b1;
        end
        bus.stb_i = 1'b0;
        checks++; if (seen !== 1'b0 || regs !== model_flat()) begin
            failures++; $display("FAIL stb_without_cyc resp=%b regs=%h required 0/%h", seen, regs, model_flat());
        end
        xfer(2'd1, 1'b0, 8'h00, 3'd2, lat, kind, rdat, wr, ra, rafter, dafter);
        model_idx = 2'd1;
        checks++; if (rdat !== model_regs[1] || lat !== 3) begin
            failures++; $display("FAIL abort_readback dat=%h lat=%0d required %h/3", rdat, lat, model_regs[1]);
        end
    endtask

    task automatic test_out_of_range();
        int lat, kind; logic [7:0] rdat, dafter; logic wr, rafter; logic [23:0] ra;
        logic [2:0] w;
        w = 3'($urandom_range(0, MAXW));
        xfer(2'd3, 1'b1, 8'h55, w, lat, kind, rdat, wr, ra, rafter, dafter);
        model_idx = 2'd3;
        checks++; if (lat !== 1 + int'(w) || kind !== exp_kind(2'd3) || wr !== 1'b0) begin
            failures++; $display("FAIL oor_write lat=%0d kind=%0d wr=%b required %0d/%0d/0", lat, kind, wr, 1 + int'(w), exp_kind(2'd3));
        end
        checks++; if (ra !== model_flat() || reg_idx !== 2'd3) begin
            failures++; $display("FAIL oor_regs got=%h idx=%0d required %h/3", ra, reg_idx, model_flat());
        end
        xfer(2'd3, 1'b0, 8'h00, 3'd0, lat, kind, rdat, wr, ra, rafter, dafter);
        checks++; if (rdat !== 8'h00 || kind !== exp_kind(2'd3)) begin
            failures++; $display("FAIL oor_read dat=%h kind=%0d required 00/%0d", rdat, kind, exp_kind(2'd3));
        end
    endtask

    task automatic test_random();
        int lat, kind; logic [7:0] rdat, dafter; logic wr, rafter; logic [23:0] ra;
        logic [1:0] adr; logic we; logic [7:0] dat; logic [2:0] w; logic [7:0] exp_rd;
        bit in_rng;
        for (int i = 0; i < 40; i++) begin
            adr = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1));
            dat = 8'($urandom); w = 3'($urandom_range(0, MAXW));
            in_rng = (int'(adr) < NREGS);
            exp_rd = (!we && in_rng) ? model_regs[adr] : 8'h00;
            xfer(adr, we, dat, w, lat, kind, rdat, wr, ra, rafter, dafter);
            if (we && in_rng) model_regs[adr] = dat;
            model_idx = adr;
            checks++; if (lat !== 1 + int'(w) || kind !== exp_kind(adr) || wr !== (we & in_rng)) begin
                failures++; $display("FAIL rand_%0d_resp adr=%0d we=%b lat=%0d kind=%0d wr=%b required %0d/%0d/%b", i, adr, we, lat, kind, wr, 1 + int'(w), exp_kind(adr), we & in_rng);
            end
            checks++; if ((!we && rdat !== exp_rd) || ra !== model_flat() || reg_idx !== adr || rafter !== 1'b0) begin
                failures++; $display("FAIL rand_%0d_data dat=%h regs=%h idx=%0d after=%b required %h/%h/%0d/0", i, rdat, ra, reg_idx, rafter, exp_rd, model_flat(), adr);
            end
        end
    endtask

    task automatic test_reset_in_ack();
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = 2'd1;
        bus.dat_i = 8'h7E; wait_cfg = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.ack_o !== 1'b1 || regs[15:8] !== 8'h7E) begin
            failures++; $display("FAIL rst_ack_pre ack=%b reg1=%h required 1/7E", bus.ack_o, regs[15:8]);
        end
        rst = 1'b1; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        @(posedge clk); #1;
        model_reset();
        checks++; if (bus.ack_o !== 1'b0 || reg_wr !== 1'b0 || regs !== 24'h0 || reg_idx !== 2'd0 || bus.dat_o !== 8'h00) begin
            failures++; $display("FAIL rst_in_ack ack=%b wr=%b regs=%h idx=%0d dat=%h required 0/0/000000/0/00", bus.ack_o, reg_wr, regs, reg_idx, bus.dat_o);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_wait();
        test_back_to_back();
        test_abort();
        test_out_of_range();
        test_random();
        test_reset_in_ack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
